sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Sequences the board's external 16-bit asynchronous SRAM: 20-bit address, active-low chip enable, output enable, write enable and byte lanes.
- Shares the SRAM between two requesters:
  - port A: game-logic master, read/write, byte-enabled.
  - port B: row/display scanner, read-only.
- Sits between those masters and the top-level SRAM pins.
- Performs one access at a time through a fixed-timing FSM and signals completion per port with a one-cycle ack.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width; byte lanes = DATA_W/8 = 2.
- RD_CYCLES, 2, cycles CE_N/OE_N held low per read; minimum 1.
- WR_CYCLES, 2, cycles CE_N/WE_N held low per write; minimum 1.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A request; level, held until a_ack.
- a_we  in  1  1 = write, 0 = read; stable while a_req.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_be  in  2  port A byte enables; [0] = low byte, [1] = high byte.
- a_ack  out  1  one-cycle completion pulse.
- a_rdata  out  DATA_W  read data; valid while a_ack=1, holds until next A read completes.
- b_req  in  1  port B read request.
- b_addr  in  ADDR_W  port B word address.
- b_ack  out  1  one-cycle completion pulse.
- b_rdata  out  DATA_W  read data; valid while b_ack=1.
- sram_DQ  inout  DATA_W  SRAM data bus.
- sram_ADDR  out  ADDR_W  SRAM address.
- sram_LB_N, sram_UB_N, sram_CE_N, sram_OE_N, sram_WE_N  out  1 each  SRAM controls, active low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, immediate):
  - all *_N outputs = 1.
  - sram_ADDR = 0.
  - sram_DQ released (high-Z).
  - a_ack = b_ack = 0; a_rdata = b_rdata = 0; busy = 0.
  - FSM = IDLE.
  - In-flight access is dropped with no ack.
- All SRAM pins and acks are driven from registers; there are no combinational paths from inputs to pins.
- FSM has three states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any req is high, grant one port at the clock edge.
  - Latch address, write flag, write data and byte enables; port B is always read with be = 2'b11.
  - Load the cycle counter with RD_CYCLES or WR_CYCLES, then go to ACCESS.
  - If no req is high, stay in IDLE with pins inactive.
- ACCESS:
  - CE_N = 0; LB_N = ~be[0]; UB_N = ~be[1]; sram_ADDR = latched address.
  - Read: OE_N = 0, WE_N = 1, DQ high-Z.
  - Write: OE_N = 1, WE_N = 0, DQ driven with latched data.
  - Counter decrements each cycle.
  - On the last cycle, a read samples sram_DQ into the granted port's rdata register at the closing edge. Then go to RECOVER.
- RECOVER (exactly 1 cycle):
  - CE_N, OE_N, WE_N, LB_N and UB_N are all 1.
  - A write keeps DQ driven as data hold; a read keeps DQ high-Z.
  - The granted port's ack = 1 during this cycle. Then go to IDLE.
- Latency from req first seen in IDLE (cycle 0):
  - ACCESS occupies cycles 1..N (N = RD_CYCLES or WR_CYCLES).
  - ack is high in cycle N+1.
  - Next grant is possible in cycle N+2.
  - Back-to-back throughput is one access per N+2 cycles.
- Requesters must drop req at the edge where they observe ack. A req still high in IDLE starts a new access.
- Simultaneous requests in IDLE: port B wins (fixed priority; display must not tear).
- A req arriving while busy waits; it is never lost.
- Address, data and byte-enable changes while granted are ignored because they are latched at grant.
- a_be = 2'b00 still performs a full-timing cycle with both lanes disabled; it acks normally.
- Only the granted port's rdata register updates; the other port's register holds.

Optional Feature:
- Macro: SRAM_ARBITER_ROUND_ROBIN_EN.
- When defined: a last_grant register (reset = A) is used, and on a tie the port not granted last wins. The first tie after reset therefore goes to B, and alternates A/B thereafter under continuous contention.
- When undefined: fixed B-over-A priority and no last_grant register.

Decomposition:
- Package sram_arbiter_pkg holds:
  - the state enum {IDLE, ACCESS, RECOVER}.
  - port-id constants PORT_A = 1'b0, PORT_B = 1'b1.
  - default ADDR_W/DATA_W localparams.
  - the counter width function (clog2 of max(RD_CYCLES, WR_CYCLES)) + 1.
- One sub-module, sram_arbiter_grant: combinational winner select from a_req, b_req and last_grant. It contains the ROUND_ROBIN_EN variant, so the top FSM stays unchanged.

Test Plan:
- Reset held, then released: all *_N = 1, DQ = Z, acks = 0. Assert reset mid-ACCESS of a write: on the same cycle WE_N = 1, DQ = Z, and no a_ack ever follows.
- A write addr = 0x00012, data = 0xBEEF, be = 2'b11 with WR_CYCLES = 2: WE_N low for exactly cycles 1–2, DQ = 0xBEEF in cycles 1–3, a_ack in cycle 3. A following A read of 0x00012 returns a_rdata = 0xBEEF with ack in cycle 3 of that read.
- Byte write be = 2'b01, data = 0x1234 over 0xBEEF: LB_N = 0, UB_N = 1 during ACCESS. Readback = 0xBE34 (SRAM model).
- a_req and b_req rise in the same cycle: b_ack first, a_ack exactly RD_CYCLES+2 cycles later; a_rdata unchanged by the B access.
- Both reqs held high for 8 accesses:
  - without the macro, B is granted every time and A starves.
  - with SRAM_ARBITER_ROUND_ROBIN_EN, grants alternate B, A, B, A… and busy is low for one cycle between accesses.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter.
// State encoding, port identifiers, default bus widths and the access
// cycle counter width helper.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  // One extra bit over clog2 so the counter can hold the load value itself.
  function automatic int cnt_width(input int rd_cycles, input int wr_cycles);
    int max_cycles;
    max_cycles = (rd_cycles > wr_cycles) ? rd_cycles : wr_cycles;
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/sram_arbiter_grant.sv
// Winner select between the game-logic port (A) and the scanner port (B).
// Optional macro SRAM_ARBITER_ROUND_ROBIN_EN: ties go to the port that was
// not granted last. Without it, B always wins a tie so the display never
// tears.
module sram_arbiter_grant
  import sram_arbiter_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_port
);

  // Purely combinational pick; the FSM only consumes it while IDLE.
  always_comb begin
    grant_valid = a_req | b_req;
    grant_port  = PORT_B;
    if (a_req && b_req) begin
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
`else
      grant_port = PORT_B;
`endif
    end else if (a_req) begin
      grant_port = PORT_A;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for an external asynchronous 16-bit SRAM.
// Port A reads and writes with byte enables; port B is a read-only scanner.
// One access at a time: IDLE -> ACCESS (N cycles) -> RECOVER (ack) -> IDLE.
// Every SRAM pin and ack comes straight from a register, so pin values are
// computed one cycle ahead from the next state.
// Optional macro SRAM_ARBITER_ROUND_ROBIN_EN enables alternating tie-break.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [1:0]        a_be,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  inout  wire  [DATA_W-1:0] sram_DQ,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic              sram_LB_N,
  output logic              sram_UB_N,
  output logic              sram_CE_N,
  output logic              sram_OE_N,
  output logic              sram_WE_N,
  output logic              busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = cnt_width(RD_CYCLES, WR_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_reg, state_next;

  // Access latched at grant; requester changes after grant are ignored.
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic              port_reg,  port_next;
  logic              we_reg,    we_next;
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [BE_W-1:0]   be_reg,    be_next;

  // Registered pin images.
  logic              ce_n_reg,      ce_n_next;
  logic              oe_n_reg,      oe_n_next;
  logic              we_n_reg,      we_n_next;
  logic [BE_W-1:0]   lane_n_reg,    lane_n_next;
  logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
  logic              dq_oe_reg,     dq_oe_next;
  logic [DATA_W-1:0] dq_out_reg,    dq_out_next;

  logic              a_ack_reg,   a_ack_next;
  logic              b_ack_reg,   b_ack_next;
  logic [DATA_W-1:0] a_rdata_reg, a_rdata_next;
  logic [DATA_W-1:0] b_rdata_reg, b_rdata_next;

  logic grant_valid;
  logic grant_port;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
  logic last_grant_reg, last_grant_next;
`endif

  sram_arbiter_grant u_grant (
    .a_req       (a_req),
    .b_req       (b_req),
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    .last_grant  (last_grant_reg),
`endif
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // Per-lane tristate: the bus is driven only while a write is in flight
  // (ACCESS plus the RECOVER data-hold cycle).
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_dq_lane
      assign sram_DQ[gi*8 +: 8] = dq_oe_reg ? dq_out_reg[gi*8 +: 8] : 8'hzz;
    end
  endgenerate

  assign sram_ADDR = sram_addr_reg;
  assign sram_LB_N = lane_n_reg[0];
  assign sram_UB_N = lane_n_reg[1];
  assign sram_CE_N = ce_n_reg;
  assign sram_OE_N = oe_n_reg;
  assign sram_WE_N = we_n_reg;
  assign a_ack     = a_ack_reg;
  assign b_ack     = b_ack_reg;
  assign a_rdata   = a_rdata_reg;
  assign b_rdata   = b_rdata_reg;
  assign busy      = (state_reg != IDLE);

  // State, latched access and pin registers; reset drops any access at once.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      port_reg      <= PORT_A;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      lane_n_reg    <= '1;
      sram_addr_reg <= '0;
      dq_oe_reg     <= 1'b0;
      dq_out_reg    <= '0;
      a_ack_reg     <= 1'b0;
      b_ack_reg     <= 1'b0;
      a_rdata_reg   <= '0;
      b_rdata_reg   <= '0;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      last_grant_reg <= PORT_A;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      port_reg      <= port_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      ce_n_reg      <= ce_n_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      lane_n_reg    <= lane_n_next;
      sram_addr_reg <= sram_addr_next;
      dq_oe_reg     <= dq_oe_next;
      dq_out_reg    <= dq_out_next;
      a_ack_reg     <= a_ack_next;
      b_ack_reg     <= b_ack_next;
      a_rdata_reg   <= a_rdata_next;
      b_rdata_reg   <= b_rdata_next;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
      last_grant_reg <= last_grant_next;
`endif
    end
  end

  // Next state plus the pin values that state needs, so pins change on the
  // same edge as the state.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    port_next      = port_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    be_next        = be_reg;
    ce_n_next      = 1'b1;
    oe_n_next      = 1'b1;
    we_n_next      = 1'b1;
    lane_n_next    = '1;
    sram_addr_next = sram_addr_reg;
    dq_oe_next     = 1'b0;
    dq_out_next    = dq_out_reg;
    a_ack_next     = 1'b0;
    b_ack_next     = 1'b0;
    a_rdata_next   = a_rdata_reg;
    b_rdata_next   = b_rdata_reg;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    last_grant_next = last_grant_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          port_next = grant_port;
          if (grant_port == PORT_B) begin
            we_next   = 1'b0;
            addr_next = b_addr;
            be_next   = '1;
          end else begin
            we_next    = a_we;
            addr_next  = a_addr;
            wdata_next = a_wdata;
            be_next    = a_be;
          end
          cnt_next       = we_next ? WR_LOAD : RD_LOAD;
          ce_n_next      = 1'b0;
          oe_n_next      = we_next;
          we_n_next      = ~we_next;
          lane_n_next    = ~be_next;
          sram_addr_next = addr_next;
          dq_oe_next     = we_next;
          dq_out_next    = wdata_next;
`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
          last_grant_next = grant_port;
`endif
          state_next = ACCESS;
        end
      end

      ACCESS: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          // Closing edge: capture read data, strobes off, write data held.
          state_next = RECOVER;
          dq_oe_next = we_reg;
          if (port_reg == PORT_B) begin
            b_ack_next = 1'b1;
            if (!we_reg) begin
              b_rdata_next = sram_DQ;
            end
          end else begin
            a_ack_next = 1'b1;
            if (!we_reg) begin
              a_rdata_next = sram_DQ;
            end
          end
        end else begin
          ce_n_next   = 1'b0;
          oe_n_next   = we_reg;
          we_n_next   = ~we_reg;
          lane_n_next = ~be_reg;
          dq_oe_next  = we_reg;
        end
      end

      RECOVER: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
